// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath (fetch/decode/execute/mem/writeback).
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs mostly Moore.
// Backpressure: mem_req is held until mem_ready; a watchdog traps stalled accesses into ERROR.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_UPPER  = 4'd12,
    S_ERROR  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Last wait count at which a late mem_ready is still accepted.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        illegal_q, illegal_d;
  logic        timed_out;
  logic        br_take;
  logic        br_legal;

  // funct7b5 only matters to the ALU decoder downstream, not to sequencing.
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  assign timed_out = (wait_cnt_q >= TIMEOUT_LAST);

  // Branch condition from funct3; 010/011 are not branch encodings.
  always_comb begin
    br_take  = 1'b0;
    br_legal = 1'b1;
    case (funct3)
      3'b000:          br_take = Zero;
      3'b001:          br_take = !Zero;
      3'b100, 3'b110:  br_take = ALUR31;
      3'b101, 3'b111:  br_take = !ALUR31;
      default:         br_legal = 1'b0;
    endcase
  end

  // Next-state and control decode; reset forces every enable low combinationally.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    ResultSrc = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        // Precompute OldPC + branch offset into ALUOut while dispatching.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
        if (op == OP_LOAD || op == OP_STORE)           state_d = S_MEMADR;
        else if (op == OP_REG)                         state_d = S_EXR;
        else if (op == OP_IMM)                         state_d = S_EXI;
        else if (op == OP_BRANCH)                      state_d = S_BRANCH;
        else if (op == OP_JAL)                         state_d = S_JAL;
        else if (op == OP_JALR)                        state_d = S_JALR;
        else if (!op[6] && op[4:0] == 5'b10111)        state_d = S_UPPER;
        else                                           state_d = S_ERROR;
      end
      S_MEMADR: begin
        // op[5] separates store from load once dispatch has narrowed op.
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'b010 : 3'b000;
        state_d = op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)      state_d = S_MEMWB;
        else if (timed_out) state_d = S_ERROR;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready)      state_d = S_FETCH;
        else if (timed_out) state_d = S_ERROR;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
        case (funct3)
          3'b000, 3'b100: ImmSrc = 3'b000;
          3'b011:         ImmSrc = 3'b001;
          3'b001, 3'b101: ImmSrc = 3'b101;
          default:        state_d = S_ERROR;
        endcase
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE.
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b01;
        ResultSrc = 2'b00;
        PCWrite   = br_take && br_legal;
        state_d   = br_legal ? S_FETCH : S_ERROR;
      end
      S_JAL: begin
        // PC takes the target in ALUOut; ALU forms OldPC+4 for the link write.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b00;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        // rs1 + imm lands in ALUOut, then reuses the JAL redirect/link path.
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b000;
        ALUOp   = 2'b00;
        state_d = S_JAL;
      end
      S_UPPER: begin
        ImmSrc   = 3'b111;
        RegWrite = 1'b1;
        if (op[5]) begin
          ResultSrc = 2'b11;
        end else begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    if (!rst_n) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Watchdog: counts stalled memory cycles within one visit to a state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  // Sticky trap flag, set on any entry into ERROR.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_ERROR);
  end

  // State, watchdog and trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a cycle-by-cycle expectation queue.
// Each step queues the expected control word, then compares it mid-cycle.
// TIMEOUT_CYCLES is 4 so watchdog boundaries are reachable quickly.
module tb_multicycle_controller;

  localparam int unsigned TO = 4;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXR    = 4'd6;
  localparam logic [3:0] EXI    = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] JAL    = 4'd10;
  localparam logic [3:0] JALR   = 4'd11;
  localparam logic [3:0] UPPER  = 4'd12;
  localparam logic [3:0] ERROR  = 4'd13;

  // Enable order: mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_FETCH = 6'b100110;
  localparam logic [5:0] E_WAITF = 6'b100000;
  localparam logic [5:0] E_MRD   = 6'b101000;
  localparam logic [5:0] E_MWR   = 6'b111000;
  localparam logic [5:0] E_PC    = 6'b000010;
  localparam logic [5:0] E_RW    = 6'b000001;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       ALUR31;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0] ImmSrc;
  logic       illegal;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    logic [15:0] mask;
  } exp_t;

  exp_t sb[$];

  multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ALUR31(ALUR31), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  // Queue the expected control word; mx = {ImmSrc, ResultSrc}, cm selects which of those to check.
  task automatic expect_step(input string tag, input logic [3:0] st, input logic [5:0] en,
                             input logic ill, input logic [4:0] mx, input logic [1:0] cm);
    exp_t e;
    e.tag  = tag;
    e.exp  = {st, en, ill, mx};
    e.mask = {11'h7FF, {3{cm[1]}}, {2{cm[0]}}};
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against what the DUT drives now.
  task automatic check_step();
    exp_t e;
    logic [15:0] o;
    e = sb.pop_front();
    o = {state_o, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal, ImmSrc, ResultSrc};
    checks++;
    assert ((o & e.mask) === (e.exp & e.mask))
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b mask=%b", e.tag, o, e.exp, e.mask);
    end
  endtask

  // One clock of the sequence: called #1 after a rising edge, samples at the falling edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [5:0] en,
                     input logic ill, input logic [4:0] mx = 5'b0, input logic [1:0] cm = 2'b00);
    expect_step(tag, st, en, ill, mx, cm);
    @(negedge clk);
    check_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    cyc(tag, FETCH, E_NONE, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0;
    Zero = 1'b0; ALUR31 = 1'b0; mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    cyc("reset", FETCH, E_NONE, 1'b0);

    // addi x1,x0,5: four cycles, RegWrite only in the last
    rst_n = 1'b1; mem_ready = 1'b1; op = OP_IMM; funct3 = 3'b000;
    cyc("addi_fetch",  FETCH,  E_FETCH, 1'b0, {3'b000, 2'b10}, 2'b01);
    cyc("addi_decode", DECODE, E_NONE,  1'b0, {3'b100, 2'b00}, 2'b10);
    cyc("addi_exi",    EXI,    E_NONE,  1'b0, {3'b000, 2'b00}, 2'b10);
    cyc("addi_wb",     ALUWB,  E_RW,    1'b0, {3'b000, 2'b00}, 2'b01);

    // lw with three stalled cycles; ready arrives at wait count TO-1
    op = OP_LOAD; funct3 = 3'b010;
    cyc("lw_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("lw_decode", DECODE, E_NONE,  1'b0);
    mem_ready = 1'b0;
    cyc("lw_madr",   MEMADR, E_NONE,  1'b0, {3'b000, 2'b00}, 2'b10);
    for (int i = 0; i < 3; i++) cyc("lw_stall", MEMRD, E_MRD, 1'b0);
    mem_ready = 1'b1;
    cyc("lw_done",   MEMRD,  E_MRD,   1'b0);
    cyc("lw_wb",     MEMWB,  E_RW,    1'b0, {3'b000, 2'b01}, 2'b01);

    // sw completes in one memory cycle
    op = OP_STORE;
    cyc("sw_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("sw_decode", DECODE, E_NONE,  1'b0);
    cyc("sw_madr",   MEMADR, E_NONE,  1'b0, {3'b010, 2'b00}, 2'b10);
    cyc("sw_wr",     MEMWR,  E_MWR,   1'b0);

    // Branches: beq taken, bne not taken, blt taken, bgeu not taken
    op = OP_BR; funct3 = 3'b000; Zero = 1'b1; ALUR31 = 1'b0;
    cyc("beq_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("beq_decode", DECODE, E_NONE,  1'b0);
    cyc("beq_branch", BRANCH, E_PC,    1'b0);
    funct3 = 3'b001;
    cyc("bne_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("bne_decode", DECODE, E_NONE,  1'b0);
    cyc("bne_branch", BRANCH, E_NONE,  1'b0);
    funct3 = 3'b100; Zero = 1'b0; ALUR31 = 1'b1;
    cyc("blt_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("blt_decode", DECODE, E_NONE,  1'b0);
    cyc("blt_branch", BRANCH, E_PC,    1'b0);
    funct3 = 3'b111;
    cyc("bgeu_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("bgeu_decode", DECODE, E_NONE,  1'b0);
    cyc("bgeu_branch", BRANCH, E_NONE,  1'b0);

    // lui / auipc
    op = OP_LUI;
    cyc("lui_fetch",    FETCH,  E_FETCH, 1'b0);
    cyc("lui_decode",   DECODE, E_NONE,  1'b0);
    cyc("lui_upper",    UPPER,  E_RW,    1'b0, {3'b111, 2'b11}, 2'b11);
    op = OP_AUIPC;
    cyc("auipc_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("auipc_decode", DECODE, E_NONE,  1'b0);
    cyc("auipc_upper",  UPPER,  E_RW,    1'b0, {3'b111, 2'b10}, 2'b11);

    // jalr goes through the JAL redirect/link path; jal directly
    op = OP_JALR; funct3 = 3'b000;
    cyc("jalr_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("jalr_decode", DECODE, E_NONE,  1'b0);
    cyc("jalr_exec",   JALR,   E_NONE,  1'b0, {3'b000, 2'b00}, 2'b10);
    cyc("jalr_jal",    JAL,    E_PC,    1'b0, {3'b000, 2'b00}, 2'b01);
    cyc("jalr_wb",     ALUWB,  E_RW,    1'b0);
    op = OP_JAL;
    cyc("jal_fetch",   FETCH,  E_FETCH, 1'b0);
    cyc("jal_decode",  DECODE, E_NONE,  1'b0);
    cyc("jal_jal",     JAL,    E_PC,    1'b0);
    cyc("jal_wb",      ALUWB,  E_RW,    1'b0);

    // R-type
    op = OP_REG;
    cyc("add_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("add_decode", DECODE, E_NONE,  1'b0);
    cyc("add_exr",    EXR,    E_NONE,  1'b0);
    cyc("add_wb",     ALUWB,  E_RW,    1'b0);

    // I-type with an unsupported funct3 traps from EXI
    op = OP_IMM; funct3 = 3'b010;
    cyc("exi_bad_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("exi_bad_decode", DECODE, E_NONE,  1'b0);
    cyc("exi_bad_exi",    EXI,    E_NONE,  1'b0);
    cyc("exi_bad_err",    ERROR,  E_NONE,  1'b1);
    cyc("exi_bad_stick",  ERROR,  E_NONE,  1'b1);
    do_reset("exi_bad_rst");

    // Branch funct3 011 traps without redirecting even though conditions look taken
    op = OP_BR; funct3 = 3'b011; Zero = 1'b1; ALUR31 = 1'b1;
    cyc("br_bad_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("br_bad_decode", DECODE, E_NONE,  1'b0);
    cyc("br_bad_branch", BRANCH, E_NONE,  1'b0);
    cyc("br_bad_err",    ERROR,  E_NONE,  1'b1);
    do_reset("br_bad_rst");

    // Illegal opcode: sticky ERROR, memory handshake ignored, cleared by reset
    op = OP_BAD;
    cyc("ill_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("ill_decode", DECODE, E_NONE,  1'b0);
    for (int i = 0; i < 3; i++) cyc("ill_err", ERROR, E_NONE, 1'b1);
    do_reset("ill_rst");

    // Watchdog: fetch never answered; ERROR after TO stalled cycles
    op = OP_IMM; funct3 = 3'b000; mem_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) cyc("to_wait", FETCH, E_WAITF, 1'b0);
    cyc("to_err",   ERROR, E_NONE, 1'b1);
    mem_ready = 1'b1;
    cyc("to_stick", ERROR, E_NONE, 1'b1);
    do_reset("to_rst");

    // Reset in the middle of a stalled store drops the write at once
    op = OP_STORE; mem_ready = 1'b1;
    cyc("abort_fetch",  FETCH,  E_FETCH, 1'b0);
    cyc("abort_decode", DECODE, E_NONE,  1'b0);
    mem_ready = 1'b0;
    cyc("abort_madr",   MEMADR, E_NONE,  1'b0);
    cyc("abort_wr",     MEMWR,  E_MWR,   1'b0);
    rst_n = 1'b0;
    cyc("abort_rst",    FETCH,  E_NONE,  1'b0);
    rst_n = 1'b1; mem_ready = 1'b1;
    cyc("abort_restart", FETCH, E_FETCH, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
